shift_unit_pipe: RTL and testbench

// - Pipelined, parametrised barrel shifter with valid/ready handshake; successor to the

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_stage.sv | 54 +++++
 rtl/shift_unit_pipe.sv | 122 ++++++++++++
 tb/tb_shift_unit_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter: operation modes, shift direction
// and the per-op control word carried down the pipeline alongside the data.
package shift_pkg;

  typedef enum logic [1:0] {
    SHM_SHL  = 2'd0,
    SHM_SHR  = 2'd1,
    SHM_SSHR = 2'd2,
    SHM_ROR  = 2'd3
  } shift_mode_e;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } shift_dir_e;

  typedef struct packed {
    shift_dir_e dir;
    logic       rot;
    logic       arith;
    logic       sign;
  } shift_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One registered pipeline stage: shifts/rotates by STEP when the matching bit of
// the decoded magnitude is set, and passes valid, control and amount along.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int LG    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              src_valid,
  input  logic [WIDTH-1:0]  src_data,
  input  shift_ctrl_t       src_ctrl,
  input  logic [LG-1:0]     src_amt,
  output logic              dst_valid,
  output logic [WIDTH-1:0]  dst_data,
  output shift_ctrl_t       dst_ctrl,
  output logic [LG-1:0]     dst_amt
);

  localparam int BIT = $clog2(STEP);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = src_data;
    if (src_amt[BIT]) begin
      if (src_ctrl.dir == DIR_L) begin
        shifted = src_ctrl.rot ? {src_data[WIDTH-STEP-1:0], src_data[WIDTH-1:WIDTH-STEP]}
                               : {src_data[WIDTH-STEP-1:0], {STEP{1'b0}}};
      end else begin
        shifted = src_ctrl.rot ? {src_data[STEP-1:0], src_data[WIDTH-1:STEP]}
                               : {{STEP{src_ctrl.arith & src_ctrl.sign}}, src_data[WIDTH-1:STEP]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_valid <= 1'b0;
      dst_data  <= '0;
      dst_ctrl  <= '0;
      dst_amt   <= '0;
    end else if (en) begin
      dst_valid <= src_valid;
      dst_data  <= shifted;
      dst_ctrl  <= src_ctrl;
      dst_amt   <= src_amt;
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter with valid/ready handshake: a decode stage resolves
// direction, magnitude and out-of-range cases, then log2(WIDTH) shift stages follow.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SHW        = 4,
  parameter bit AMT_SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_amt,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);

  localparam int            LG        = $clog2(WIDTH);
  localparam logic [SHW:0]  MAG_ONE   = (SHW+1)'(1);
  localparam logic [SHW:0]  MAG_WIDTH = (SHW+1)'(WIDTH);

  logic             advance;
  logic [SHW:0]     amt_ext;
  logic [SHW:0]     mag;
  logic             neg;
  logic             out_range;
  shift_ctrl_t      dec_ctrl;
  logic [WIDTH-1:0] dec_data;
  logic [LG-1:0]    dec_amt;

  logic             s0_valid_reg;
  logic [WIDTH-1:0] s0_data_reg;
  shift_ctrl_t      s0_ctrl_reg;
  logic [LG-1:0]    s0_amt_reg;

  logic             valid_s [0:LG];
  logic [WIDTH-1:0] data_s  [0:LG];
  shift_ctrl_t      ctrl_s  [0:LG];
  logic [LG-1:0]    amt_s   [0:LG];
  logic             unused_tail;

  assign advance  = !valid_s[LG] || out_ready;
  assign in_ready = advance;

  // Magnitude is formed one bit wider than in_amt so the most-negative amount negates cleanly.
  always_comb begin
    amt_ext = AMT_SIGNED ? {in_amt[SHW-1], in_amt} : {1'b0, in_amt};
    neg     = AMT_SIGNED && in_amt[SHW-1];
    mag     = neg ? (~amt_ext + MAG_ONE) : amt_ext;
    out_range = (mag >= MAG_WIDTH);

    dec_ctrl      = '0;
    dec_ctrl.sign = in_data[WIDTH-1];
    case (shift_mode_e'(in_mode))
      SHM_SHL:  dec_ctrl.dir = neg ? DIR_R : DIR_L;
      SHM_SHR:  dec_ctrl.dir = neg ? DIR_L : DIR_R;
      SHM_SSHR: begin
        dec_ctrl.dir   = neg ? DIR_L : DIR_R;
        dec_ctrl.arith = !neg;
      end
      default: begin
        dec_ctrl.dir = neg ? DIR_L : DIR_R;
        dec_ctrl.rot = 1'b1;
      end
    endcase

    dec_data = in_data;
    dec_amt  = mag[LG-1:0];
    if (out_range && !dec_ctrl.rot) begin
      dec_amt  = '0;
      dec_data = dec_ctrl.arith ? {WIDTH{in_data[WIDTH-1]}} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_reg <= 1'b0;
      s0_data_reg  <= '0;
      s0_ctrl_reg  <= '0;
      s0_amt_reg   <= '0;
    end else if (advance) begin
      s0_valid_reg <= in_valid;
      s0_data_reg  <= dec_data;
      s0_ctrl_reg  <= dec_ctrl;
      s0_amt_reg   <= dec_amt;
    end
  end

  assign valid_s[0] = s0_valid_reg;
  assign data_s[0]  = s0_data_reg;
  assign ctrl_s[0]  = s0_ctrl_reg;
  assign amt_s[0]   = s0_amt_reg;

  for (genvar gi = 1; gi <= LG; gi++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << (gi - 1)),
      .LG    (LG)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .src_valid (valid_s[gi-1]),
      .src_data  (data_s[gi-1]),
      .src_ctrl  (ctrl_s[gi-1]),
      .src_amt   (amt_s[gi-1]),
      .dst_valid (valid_s[gi]),
      .dst_data  (data_s[gi]),
      .dst_ctrl  (ctrl_s[gi]),
      .dst_amt   (amt_s[gi])
    );
  end

  assign out_valid   = valid_s[LG];
  assign out_data    = data_s[LG];
  assign unused_tail = ^{ctrl_s[LG], amt_s[LG]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench: an unsigned-amount and a signed-amount instance share stimulus;
// expected results are queued on accept and compared as each result drains.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic [3:0] in_amt = '0;
  logic [1:0] in_mode = '0;
  logic       in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [7:0] out_data_u, out_data_s;

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(8), .SHW(4), .AMT_SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u)
  );

  shift_unit_pipe #(.WIDTH(8), .SHW(4), .AMT_SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s)
  );

  typedef struct {
    shift_mode_e mode;
    logic [7:0]  data;
    logic [3:0]  amt;
    logic [7:0]  exp_u;
    logic [7:0]  exp_s;
  } vec_t;

  typedef struct {
    logic [7:0] exp_u;
    logic [7:0] exp_s;
  } exp_t;

  vec_t vec [19];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = v.mode;
    in_data  = v.data;
    in_amt   = v.amt;
    while (!in_ready_u && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready_u) begin
      check("accept_timeout", in_ready_u, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{v.exp_u, v.exp_s});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard pop, handshake and hold checks, all away from posedge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      check("in_ready", in_ready_u, !(out_valid_u && !out_ready));
      check("valid_match", out_valid_s, out_valid_u);
      if (hold_pend) begin
        check("hold_valid", out_valid_u, 1);
        check("hold_data", out_data_u, hold_data);
      end
      hold_pend = out_valid_u && !out_ready;
      hold_data = out_data_u;
      if (out_valid_u && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_valid_u, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          $display("tx %0d: unsigned out=%h exp=%h | signed out=%h exp=%h",
                   n_out, out_data_u, e.exp_u, out_data_s, e.exp_s);
          check("data_unsigned", out_data_u, e.exp_u);
          check("data_signed", out_data_s, e.exp_s);
        end
      end
    end
  end

  initial begin
    int lat;
    int outs_before;
    int stray;

    vec[0]  = '{SHM_SHL,  8'h81, 4'h1, 8'h02, 8'h02};
    vec[1]  = '{SHM_SHR,  8'h81, 4'h1, 8'h40, 8'h40};
    vec[2]  = '{SHM_SSHR, 8'h80, 4'h3, 8'hF0, 8'hF0};
    vec[3]  = '{SHM_SSHR, 8'h80, 4'hF, 8'hFF, 8'h00};
    vec[4]  = '{SHM_SHR,  8'hFF, 4'h9, 8'h00, 8'h80};
    vec[5]  = '{SHM_ROR,  8'h81, 4'h1, 8'hC0, 8'hC0};
    vec[6]  = '{SHM_ROR,  8'h81, 4'h9, 8'hC0, 8'hC0};
    vec[7]  = '{SHM_ROR,  8'h81, 4'h0, 8'h81, 8'h81};
    vec[8]  = '{SHM_SHL,  8'h10, 4'hE, 8'h00, 8'h04};
    vec[9]  = '{SHM_SSHR, 8'h41, 4'hF, 8'h00, 8'h82};
    vec[10] = '{SHM_SHL,  8'hFF, 4'h8, 8'h00, 8'h00};
    vec[11] = '{SHM_ROR,  8'h81, 4'hF, 8'h03, 8'h03};
    vec[12] = '{SHM_SSHR, 8'h96, 4'h2, 8'hE5, 8'hE5};
    vec[13] = '{SHM_SHL,  8'h0F, 4'h7, 8'h80, 8'h80};
    vec[14] = '{SHM_SSHR, 8'h7F, 4'h8, 8'h00, 8'h00};
    vec[15] = '{SHM_SHR,  8'hA5, 4'h0, 8'hA5, 8'hA5};
    vec[16] = '{SHM_SSHR, 8'hC3, 4'h9, 8'hFF, 8'h80};
    vec[17] = '{SHM_ROR,  8'h3C, 4'hC, 8'hC3, 8'hC3};
    vec[18] = '{SHM_SHL,  8'h80, 4'hA, 8'h00, 8'h02};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", out_valid_u, 0);
    check("reset_out_data", out_data_u, 0);
    check("reset_in_ready", in_ready_u, 1);
    check("reset_out_data_s", out_data_s, 0);

    // Latency with no stalls: the accepting edge counts as cycle 1.
    send(vec[0]);
    lat = 1;
    while (!out_valid_u && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 4);
    drain();

    for (int i = 0; i < 19; i++) send(vec[i]);
    drain();

    // Backpressure: six back-to-back ops with out_ready low for three cycles mid-stream.
    outs_before = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vec[i + 2]);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - outs_before, 6);

    // Reset with three ops in flight: nothing from them may ever appear.
    for (int i = 0; i < 3; i++) send(vec[i + 9]);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_flush_valid", out_valid_u, 0);
    check("rst_flush_valid_s", out_valid_s, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_u, 1);
    stray = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid_u || out_valid_s) stray++;
    end
    check("rst_no_stale", stray, 0);

    send(vec[17]);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
